dcdl_coarse_ctrl: RTL



---
 rtl/dcdl_coarse_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/dcdl_coarse_ctrl.sv
// Coarse DCDL sequencer: binary target code to a registered thermometer select,
// applied as one jump or as a one-bit-per-step ramp with a settle wait after each change.
module dcdl_coarse_ctrl #(
  parameter int Nbit     = 5,
  parameter int Nthm     = 2**Nbit-1,
  parameter int MAX_CODE = 31,
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [Nbit-1:0]     code_in,
  input  logic                code_valid,
  output logic                code_ready,
  input  logic                en_ramp,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [Nthm-1:0]     thm,
  output logic [Nbit-1:0]     code_cur,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE
  } state_t;

  localparam logic [Nbit-1:0] MAXC = Nbit'(MAX_CODE);

  state_t                state;
  logic [Nbit-1:0]       target;
  logic [SETTLE_W-1:0]   cnt;
  logic [Nbit-1:0]       clamp;
  logic [Nbit-1:0]       step_code;

  function automatic logic [Nthm-1:0] therm(input logic [Nbit-1:0] c);
    logic [Nthm-1:0] t;
    for (int i = 0; i < Nthm; i++)
      t[i] = (i < int'(c));
    return t;
  endfunction

  assign clamp      = (code_in > MAXC) ? MAXC : code_in;
  assign code_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Ramp direction comes from the latched target only.
  always_comb begin
    step_code = code_cur;
    unique case (1'b1)
      (code_cur < target): step_code = code_cur + 1'b1;
      (code_cur > target): step_code = code_cur - 1'b1;
      default:             step_code = code_cur;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      thm      <= '0;
      code_cur <= '0;
      target   <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (code_valid) begin
            target <= clamp;
            if (clamp == code_cur) begin
              done <= 1'b1;
            end else if (!en_ramp) begin
              code_cur <= clamp;
              thm      <= therm(clamp);
              cnt      <= settle_cycles;
              state    <= SETTLE;
            end else begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          code_cur <= step_code;
          thm      <= therm(step_code);
          cnt      <= settle_cycles;
          state    <= SETTLE;
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - SETTLE_W'(1);
          end else if (code_cur == target) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state <= STEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
